// File: rtl/multibyte_compare_sequencer.sv
// multibyte_compare_sequencer: compares two NBYTES-wide operands one byte per cycle, MSB byte first, stopping at the first unequal byte
// Ports: clk, rst (sync, active-high); start, a_in, b_in (request, operands sampled when idle);
//        busy, done (one-cycle pulse); less/equal/greater, bytes_used (held until the next accepted start).
// Build option: define SIGNED_COMPARE_EN to treat the operands as two's complement.
module eight_bit_comparator (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       lin,
  input  logic       ein,
  input  logic       gin,
  output logic       lout,
  output logic       eout,
  output logic       gout
);
  assign lout = (a < b) | ((a == b) & lin);
  assign eout = (a == b) & ein;
  assign gout = (a > b) | ((a == b) & gin);
endmodule

module multibyte_compare_sequencer #(
  parameter int NBYTES = 4,
  parameter int CW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] a_in,
  input  logic [8*NBYTES-1:0] b_in,
  output logic                busy,
  output logic                done,
  output logic                less,
  output logic                equal,
  output logic                greater,
  output logic [CW-1:0]       bytes_used
);
  localparam int IW = $clog2(NBYTES);
  typedef enum logic {IDLE, CMP} state_t;
  state_t state, state_n;
  logic [8*NBYTES-1:0] a_reg, b_reg;
  logic [IW-1:0] idx;
  logic [7:0] a_byte, b_byte;
  logic lt, eq, gt, last;
`ifdef SIGNED_COMPARE_EN
  // Flipping the sign bit of the top byte maps two's complement order onto unsigned order.
  logic msb;
  assign msb = idx == IW'(NBYTES - 1);
  assign a_byte = a_reg[idx*8 +: 8] ^ {msb, 7'b0};
  assign b_byte = b_reg[idx*8 +: 8] ^ {msb, 7'b0};
`else
  assign a_byte = a_reg[idx*8 +: 8];
  assign b_byte = b_reg[idx*8 +: 8];
`endif
  eight_bit_comparator u_cmp (
    .a(a_byte), .b(b_byte), .lin(1'b0), .ein(1'b1), .gin(1'b0),
    .lout(lt), .eout(eq), .gout(gt)
  );
  assign busy = state == CMP;
  assign last = !eq || idx == '0;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = start ? CMP : IDLE;
    else state_n = last ? IDLE : CMP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      less <= 1'b0;
      equal <= 1'b0;
      greater <= 1'b0;
      bytes_used <= '0;
      idx <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        a_reg <= a_in;
        b_reg <= b_in;
        idx <= IW'(NBYTES - 1);
        less <= 1'b0;
        equal <= 1'b0;
        greater <= 1'b0;
      end else if (state == CMP) begin
        if (last) begin
          less <= lt;
          equal <= eq;
          greater <= gt;
          bytes_used <= CW'(NBYTES) - CW'(idx);
          done <= 1'b1;
        end else idx <= idx - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_multibyte_compare_sequencer.sv
// tb_multibyte_compare_sequencer: directed self-checking bench for multibyte_compare_sequencer (NBYTES=4)
module tb_multibyte_compare_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic busy, done, less, equal, greater;
  logic [4:0] bytes_used;
  int n_cmp = 0, n_err = 0, lat = 0;
  logic seen_done;

  multibyte_compare_sequencer #(.NBYTES(4), .CW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .less(less), .equal(equal), .greater(greater),
    .bytes_used(bytes_used)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [31:0] a, input logic [31:0] b);
    a_in = a;
    b_in = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("done_after_start", {31'b0, done}, 32'd0);
    chk("flags_cleared", {29'b0, less, equal, greater}, 32'd0);
  endtask

  task automatic wait_done();
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic result(input string tag, input int exp_lat, input logic [2:0] exp_leg, input int exp_bytes);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_lt_eq_gt"}, {29'b0, less, equal, greater}, {29'b0, exp_leg});
    chk({tag, "_bytes_used"}, {27'b0, bytes_used}, exp_bytes);
    chk({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_flags", {29'b0, less, equal, greater}, 32'd0);
    chk("reset_bytes", {27'b0, bytes_used}, 32'd0);

    go(32'h80000000, 32'h7FFFFFFF);
    wait_done();
`ifdef SIGNED_COMPARE_EN
    result("early_exit", 2, 3'b100, 1);
`else
    result("early_exit", 2, 3'b001, 1);
`endif

    go(32'hA5A5A5A5, 32'hA5A5A5A5);
    tick();
    lat++;
    chk("equal_busy_mid", {31'b0, busy}, 32'd1);
    wait_done();
    result("equal_full", 5, 3'b010, 4);
    tick();
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("equal_held", {29'b0, less, equal, greater}, 32'd2);

    go(32'h1234560A, 32'h1234560B);
    wait_done();
    result("lsb_decides", 5, 3'b100, 4);

    go(32'h00000005, 32'h00000003);
    a_in = 32'h00000000;
    b_in = 32'hFFFFFFFF;
    start = 1'b1;
    tick();
    tick();
    lat += 2;
    start = 1'b0;
    wait_done();
    result("start_ignored", 5, 3'b001, 4);

    go(32'h00000001, 32'h00000000);
    wait_done();
    result("back_to_back", 5, 3'b001, 4);

    go(32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_flags", {29'b0, less, equal, greater}, 32'd0);
    chk("abort_bytes", {27'b0, bytes_used}, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen_done |= done;
    end
    chk("abort_no_done", {31'b0, seen_done}, 32'd0);

    go(32'h00000100, 32'h00000200);
    wait_done();
    result("after_abort", 4, 3'b100, 3);

    a_in = 32'h1;
    b_in = 32'h0;
    start = 1'b1;
    rst = 1'b1;
    tick();
    start = 1'b0;
    rst = 1'b0;
    chk("rst_beats_start", {31'b0, busy}, 32'd0);
    tick();
    chk("rst_beats_start_idle", {30'b0, busy, done}, 32'd0);

    go(32'hFFFFFFFF, 32'h00000001);
    wait_done();
`ifdef SIGNED_COMPARE_EN
    result("neg_vs_pos", 2, 3'b100, 1);
`else
    result("neg_vs_pos", 2, 3'b001, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multibyte_compare_sequencer.md
Name: multibyte_compare_sequencer

Overview:
- Sequences a single eight_bit_comparator instance to compare two wide operands one byte per cycle, MSB byte first.
- Terminates early on the first unequal byte.
- Sits between a requester and the shared 8-bit compare datapath; presents a start/busy/done handshake and registered less/equal/greater results.

Parameters:
NBYTES, 4, number of bytes per operand (2..16); operand width = 8*NBYTES
CW, 5, width of bytes_used; must hold NBYTES (ceil(log2(NBYTES+1)))

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only in a cycle where busy=0
a_in  input  8*NBYTES  operand A; sampled on the accepted start
b_in  input  8*NBYTES  operand B; sampled on the accepted start
busy  output  1  compare in progress
done  output  1  one-cycle pulse; results valid from this cycle
less  output  1  A < B (held until next accepted start)
equal  output  1  A == B (held)
greater  output  1  A > B (held)
bytes_used  output  CW  number of byte compares performed, 1..NBYTES (held)

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst is synchronous, active-high, and has priority over all other inputs.
- Reset values: state=IDLE, busy=0, done=0, less=0, equal=0, greater=0, bytes_used=0.
- Comparator instance:
  - Cascade inputs tied lin=0, ein=1, gin=0, so outputs reflect the current byte pair only.
  - A-input = byte idx of captured A; B-input = byte idx of captured B.
  - idx runs NBYTES-1 down to 0.
- States: IDLE, CMP.
  - IDLE:
    - busy=0.
    - On start=1: capture a_in/b_in into internal registers, set idx=NBYTES-1, clear less/equal/greater to 0, go to CMP.
    - An accepted start in the cycle done=1 is legal.
  - CMP:
    - busy=1. Each cycle, compare byte idx.
    - If comparator less or greater: latch that flag, set equal=0, bytes_used=NBYTES-idx, pulse done, go to IDLE.
    - Else if idx==0: latch equal=1, bytes_used=NBYTES, pulse done, go to IDLE.
    - Else: idx<=idx-1.
- Latency:
  - start accepted at cycle T -> busy=1 from T+1.
  - Byte k (0 = MSB) compared in cycle T+1+k.
  - Decision at byte k -> done=1, results valid, busy=0 at cycle T+2+k.
  - Minimum 2 cycles; maximum NBYTES+1 cycles.
- Exactly one of less/equal/greater is 1 after every done. All three are 0 between an accepted start and its done.
- start while busy=1 is ignored; captured operands are unaffected by a_in/b_in changes during CMP.
- rst during CMP: abort, return to IDLE, apply reset values. No done pulse is issued for the aborted compare.
- start and rst asserted together: rst wins; start is dropped.
- Operands are unsigned unless the optional feature is compiled in.

Optional Feature:
- Macro SIGNED_COMPARE_EN.
- Defined:
  - Operands are two's complement.
  - Bit 7 of both A and B is inverted only when feeding the MSB byte (idx=NBYTES-1) to the comparator. This makes a negative operand compare less than a non-negative one.
  - Lower bytes are compared unsigned; latency is unchanged.
- Undefined: all bytes are compared unsigned, with no inversion logic present.

Test Plan (NBYTES=4):
- Reset: rst=1 for 2 cycles, then idle -> busy=0, done=0, less=equal=greater=0, bytes_used=0.
- Early exit: A=32'h80000000, B=32'h7FFFFFFF, start at T (unsigned) -> done at T+2, greater=1, bytes_used=1; with SIGNED_COMPARE_EN -> done at T+2, less=1, bytes_used=1.
- Equal, full length: A=B=32'hA5A5A5A5 -> done at T+5, equal=1, bytes_used=4, busy high T+1..T+4.
- LSB decides: A=32'h1234560A, B=32'h1234560B -> done at T+5, less=1, bytes_used=4.
- Handshake:
  - start re-asserted with new operands during busy -> ignored; original result is reported.
  - start asserted in the done cycle with A=32'h00000001, B=32'h00000000 -> busy next cycle, done 5 cycles after that with greater=1.
- Reset mid-op: A=B=32'hFFFFFFFF, rst asserted at T+2 -> no done pulse, all outputs return to reset values at T+3; a subsequent start compares correctly.
